// File: rtl/mem_block_responder.sv
// Block-granular main-memory responder: block reads return a word-serial burst, block writes return a one-beat ack.
// Optional MEM_CRITICAL_WORD_FIRST_EN starts read bursts at the requested word and wraps.
module mem_block_responder #(
  parameter int WRD_WIDTH  = 32,
  parameter int BLK_WORDS  = 4,
  parameter int MEM_BLOCKS = 256,
  parameter int PA_WIDTH   = 32,
  parameter int LATENCY    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [PA_WIDTH-1:0]            req_addr,
  input  logic [WRD_WIDTH*BLK_WORDS-1:0] req_wdata,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [WRD_WIDTH-1:0]           resp_data,
  output logic                           resp_last,
  output logic                           resp_wack
);

  localparam int OW = $clog2(BLK_WORDS);
  localparam int BW = $clog2(MEM_BLOCKS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_ACK} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [OW-1:0]    beat, beat_nxt;
  logic [OW-1:0]    word_nxt;
  logic             we_q;
  logic [BW-1:0]    blk_q;
  logic [OW-1:0]    off_q;
  logic             accept;

  logic                 resp_valid_nxt, resp_last_nxt, resp_wack_nxt;
  logic [WRD_WIDTH-1:0] resp_data_nxt;

  logic [WRD_WIDTH-1:0] mem [MEM_BLOCKS*BLK_WORDS];

  logic [BW-1:0] req_blk;
  logic [OW-1:0] req_off;
  assign req_blk = req_addr[OW+2 +: BW];
  assign req_off = req_addr[2 +: OW];

  assign accept = (state == IDLE) && req_ready && req_valid;

  // Storage has no reset; a write commits on its acceptance edge.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_we) begin
      for (int unsigned w = 0; w < BLK_WORDS; w++) begin
        mem[{req_blk, OW'(w)}] <= req_wdata[w*WRD_WIDTH +: WRD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      beat       <= '0;
      we_q       <= 1'b0;
      blk_q      <= '0;
      off_q      <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
      resp_wack  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      beat       <= beat_nxt;
      req_ready  <= (state_nxt == IDLE);
      resp_valid <= resp_valid_nxt;
      resp_data  <= resp_data_nxt;
      resp_last  <= resp_last_nxt;
      resp_wack  <= resp_wack_nxt;
      if (accept) begin
        we_q  <= req_we;
        blk_q <= req_blk;
        off_q <= req_off;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          cnt_nxt   = CW'(LATENCY - 1);
          beat_nxt  = '0;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = we_q ? WR_ACK : RD_BURST;
        else           cnt_nxt   = cnt - 1'b1;
      end
      RD_BURST: begin
        if (resp_ready) begin
          if (beat == '1) state_nxt = IDLE;
          else            beat_nxt  = beat + 1'b1;
        end
      end
      WR_ACK: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign word_nxt = beat_nxt + off_q;
`else
  assign word_nxt = beat_nxt;
`endif

  // Outputs are decoded from the next state and registered, so req_* never reaches resp_* combinationally.
  always_comb begin
    resp_valid_nxt = 1'b0;
    resp_last_nxt  = 1'b0;
    resp_wack_nxt  = 1'b0;
    resp_data_nxt  = '0;
    case (state_nxt)
      RD_BURST: begin
        resp_valid_nxt = 1'b1;
        resp_last_nxt  = (beat_nxt == '1);
        resp_data_nxt  = mem[{blk_q, word_nxt}];
      end
      WR_ACK: begin
        resp_valid_nxt = 1'b1;
        resp_last_nxt  = 1'b1;
        resp_wack_nxt  = 1'b1;
      end
      default: ;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{req_addr[1:0], req_addr[PA_WIDTH-1:OW+2+BW], off_q};

endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized self-checking bench for mem_block_responder against a block-array reference model.
module tb_mem_block_responder;

  localparam int WRD_WIDTH  = 32;
  localparam int BLK_WORDS  = 4;
  localparam int MEM_BLOCKS = 256;
  localparam int PA_WIDTH   = 32;
  localparam int LATENCY    = 4;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_we;
  logic [PA_WIDTH-1:0]            req_addr;
  logic [WRD_WIDTH*BLK_WORDS-1:0] req_wdata;
  logic                           resp_valid;
  logic                           resp_ready;
  logic [WRD_WIDTH-1:0]           resp_data;
  logic                           resp_last;
  logic                           resp_wack;

  mem_block_responder #(
    .WRD_WIDTH (WRD_WIDTH),
    .BLK_WORDS (BLK_WORDS),
    .MEM_BLOCKS(MEM_BLOCKS),
    .PA_WIDTH  (PA_WIDTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_last (resp_last),
    .resp_wack (resp_wack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WRD_WIDTH-1:0] model [MEM_BLOCKS][BLK_WORDS];
  bit                   written [MEM_BLOCKS];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = always ready, 1 = random resp_ready, 2 = ready low for 3 cycles on beat 1
  task automatic run_req(input logic we, input logic [31:0] addr,
                         input logic [127:0] wdata, input int mode);
    int n, beat, start, stall_left, b1_seen;
    int blk, off;
    logic [31:0] exp;
    blk = int'((addr >> 4) % MEM_BLOCKS);
    off = int'(addr[3:2]);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    start = off;
`else
    start = 0;
`endif
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    check("req_ready_wait", 128'(n < 100), 128'd1);
    tick();
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    req_addr  = $urandom;
    if (we) begin
      for (int i = 0; i < BLK_WORDS; i++) model[blk][i] = wdata[i*32 +: 32];
      written[blk] = 1'b1;
    end
    check("busy_req_ready", 128'(req_ready), 128'd0);
    check("early_valid", 128'(resp_valid), 128'd0);
    n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    check("latency", 128'(n), 128'(LATENCY));
    if (we) begin
      n = (mode == 1) ? $urandom_range(0, 2) : 0;
      for (int k = 0; k <= n; k++) begin
        resp_ready = (k == n);
        check("wack_valid", 128'(resp_valid), 128'd1);
        check("wack_flags", 128'({resp_wack, resp_last}), 128'b11);
        check("wack_data", 128'(resp_data), 128'd0);
        tick();
      end
    end else begin
      beat = 0; n = 0; stall_left = 3; b1_seen = 0;
      while (beat < BLK_WORDS && n < 200) begin
        if (mode == 1)                               resp_ready = 1'($urandom_range(0, 1));
        else if (mode == 2 && beat == 1 && stall_left > 0) begin resp_ready = 1'b0; stall_left--; end
        else                                         resp_ready = 1'b1;
        if (beat == 1) b1_seen++;
        exp = model[blk][(start + beat) % BLK_WORDS];
        check("rd_valid", 128'(resp_valid), 128'd1);
        check("rd_data", 128'(resp_data), 128'(exp));
        check("rd_last", 128'(resp_last), 128'(beat == BLK_WORDS - 1));
        check("rd_wack", 128'(resp_wack), 128'd0);
        if (resp_ready) beat++;
        tick();
        n++;
      end
      check("burst_done", 128'(beat), 128'(BLK_WORDS));
      if (mode == 2) check("stall_beat1_cycles", 128'(b1_seen), 128'd4);
    end
    check("post_valid", 128'(resp_valid), 128'd0);
    check("post_req_ready", 128'(req_ready), 128'd1);
  endtask

  initial begin
    logic [127:0] blk_a;
    logic [127:0] wd;
    logic [31:0]  addr;
    int           n;
    blk_a      = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < MEM_BLOCKS; i++) written[i] = 1'b0;

    tick(); tick(); tick();
    check("rst_req_ready", 128'(req_ready), 128'd0);
    check("rst_resp", 128'({resp_valid, resp_last, resp_wack}), 128'd0);
    check("rst_data", 128'(resp_data), 128'd0);
    rst_n = 1'b1;
    tick();
    check("rel_req_ready", 128'(req_ready), 128'd1);

    run_req(1'b1, 32'h0000_0040, blk_a, 0);
    run_req(1'b0, 32'h0000_0040, '0, 0);
    run_req(1'b0, 32'h0000_0040, '0, 2);
    run_req(1'b0, 32'h0000_0048, '0, 0);
    run_req(1'b0, 32'h0000_0040 + 256 * 16, '0, 0);
    run_req(1'b1, 32'h0000_0050 + 256 * 16 * 3, {32'h4, 32'h3, 32'h2, 32'h1}, 0);
    run_req(1'b0, 32'h0000_0057, '0, 1);

    // Abort a read after beat 1 has been accepted.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    n = 0;
    while (!req_ready && n < 100) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin tick(); n++; end
    check("abort_latency", 128'(n), 128'(LATENCY));
    resp_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("abort_valid", 128'(resp_valid), 128'd0);
    check("abort_req_ready", 128'(req_ready), 128'd0);
    rst_n = 1'b1;
    tick();
    check("abort_rel_ready", 128'(req_ready), 128'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) n++;
      tick();
    end
    check("abort_no_beats", 128'(n), 128'd0);
    run_req(1'b0, 32'h0000_0040, '0, 0);

    for (int t = 0; t < 80; t++) begin
      int          blk;
      logic        we;
      blk  = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFFF_F000) | (32'(blk) << 4) |
             (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      we   = !written[blk] || ($urandom_range(0, 2) == 0);
      wd   = {$urandom, $urandom, $urandom, $urandom};
      run_req(we, addr, wd, 1);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_block_responder.md
Name: mem_block_responder

Overview:
- Main-memory responder model; the far end of the cache controller's line-fill and writeback interface.
- Accepts one block-granular request at a time from the cache FSM.
- Reads return a word-serial burst after a fixed access latency; writes commit a whole block and return a single-beat acknowledge.
- Sits between the cache control unit and the testbench memory image. It is the sole backing store for fills and evictions.

Parameters:
- WRD_WIDTH, 32, bits per word.
- BLK_WORDS, 4, words per block (power of 2, ≥2).
- MEM_BLOCKS, 256, blocks of storage (power of 2).
- PA_WIDTH, 32, byte-address width.
- LATENCY, 4, cycles from request acceptance to first response beat (≥1).

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, synchronous, active-low.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request.
- req_we, input, 1, 1 = block write (eviction), 0 = block read (fill).
- req_addr, input, PA_WIDTH, byte address. Word offset = addr[log2(BLK_WORDS)+1:2]. Block index = addr >> log2(BLK_WORDS*4), modulo MEM_BLOCKS.
- req_wdata, input, WRD_WIDTH*BLK_WORDS, write block; word 0 in LSBs.
- resp_valid, output, 1, response beat valid.
- resp_ready, input, 1, consumer accepts beat.
- resp_data, output, WRD_WIDTH, read word (0 on write ack).
- resp_last, output, 1, final beat of response.
- resp_wack, output, 1, beat is a write acknowledge.

Behaviour:
- Reset values: req_ready=0 during reset, 1 on the first cycle after release. resp_valid=0, resp_data=0, resp_last=0, resp_wack=0.
- Reset aborts any request in flight; no beat is emitted afterward. Storage contents are not cleared by reset.
- States: IDLE, WAIT, RD_BURST, WR_ACK.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we, block index, word offset and wdata; load the counter with LATENCY-1; go to WAIT.
  - A write commits req_wdata to storage on this acceptance edge.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - At counter==0, go to RD_BURST (read) or WR_ACK (write).
  - First beat is valid exactly LATENCY cycles after the acceptance edge.
- RD_BURST:
  - resp_valid=1, emitting beats 0..BLK_WORDS-1 in ascending word order.
  - A beat advances only on resp_valid&&resp_ready. Under stall, resp_data, resp_last and the beat index hold.
  - resp_last=1 on beat BLK_WORDS-1. On acceptance of that beat, go to IDLE.
- WR_ACK:
  - Single beat: resp_valid=1, resp_wack=1, resp_last=1, resp_data=0.
  - Holds until resp_ready; then go to IDLE.
- req_ready is 1 only in IDLE, so no overlapping requests. A req_valid held across a busy period is accepted on the first IDLE cycle.
- Back-to-back: the request may be accepted in the IDLE cycle directly after the last beat. Minimum turnaround is 1 idle cycle.
- A read of a block written earlier returns the new data (write committed before any later read is accepted).
- Address bits above the block index are ignored (alias/wrap modulo MEM_BLOCKS). Bits [1:0] are ignored.
- The beat index wraps modulo BLK_WORDS using a log2(BLK_WORDS)-bit counter.
- Response outputs are registered; no combinational path from req_* to resp_*.

Optional Feature:
- Macro MEM_CRITICAL_WORD_FIRST_EN.
- Defined: the read burst starts at the latched word offset and wraps (offset, offset+1, …, BLK_WORDS-1, 0, …, offset-1). resp_last is asserted on the BLK_WORDS-th beat regardless of start position. Writes are unaffected.
- Undefined: the word offset is ignored and bursts always start at word 0.

Test Plan:
- Write addr=0x0000_0040, wdata={0xDDDD,0xCCCC,0xBBBB,0xAAAA}, resp_ready=1 -> resp_wack/resp_last/resp_valid high for exactly 1 cycle, 4 cycles after acceptance; req_ready returns high next cycle.
- Read addr=0x40 after that write, resp_ready=1 -> beats 0xAAAA,0xBBBB,0xCCCC,0xDDDD on 4 consecutive cycles starting 4 cycles after acceptance; resp_last on the 4th beat only.
- Same read with resp_ready low for 3 cycles during beat 1 -> 0xBBBB held stable for 3 cycles; order and count unchanged; total 4 accepted beats.
- Read addr=0x48 with MEM_CRITICAL_WORD_FIRST_EN -> 0xCCCC,0xDDDD,0xAAAA,0xBBBB with resp_last on 0xBBBB. Without the macro -> 0xAAAA first.
- Alias: write addr=0x40, then read addr=0x40+256*16 -> same data returned.
- rst_n low for 1 cycle mid-burst (after beat 1) -> resp_valid=0 next cycle, no further beats; req_ready=1 after release; subsequent read of 0x40 returns the original data.
